// File: rtl/daq_fifo_readout.sv
// daq_fifo_readout
// Read-side controller for the 16 channel sample FIFOs and the L1A/sample
// header FIFO. For each queued event it pops one header, then drains
// WPS*(SAMP_MAX+1) rows from all channel FIFOs. The event leaves as a 16-bit
// valid/ready stream: 4 header words, 16 data words per row, 1 trailer word.
// All outputs are registered, so there is no combinational path from
// DOUT_READY to any output.

module daq_fifo_readout #(
  parameter int WPS    = 6,
  parameter int RD_LAT = 1
) (
  input  logic         CLK40,
  input  logic         srst,
  input  logic         RDY,
  input  logic [43:0]  L1A_SMP_OUT,
  input  logic [191:0] DOUT_16CH,
  input  logic [6:0]   SAMP_MAX,
  output logic         L1A_RD_EN,
  output logic [15:0]  RD_ENA,
  output logic [15:0]  DOUT,
  output logic         DOUT_VALID,
  input  logic         DOUT_READY,
  output logic         DOUT_SOF,
  output logic         DOUT_EOF,
  output logic         BUSY,
  output logic [15:0]  EVT_CNT
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HWAIT = 3'd1,
    S_HDR   = 3'd2,
    S_DRD   = 3'd3,
    S_DWAIT = 3'd4,
    S_DOUT  = 3'd5,
    S_TRL   = 3'd6
  } state_t;

  // The header pop is registered, so it is seen by the FIFO one cycle after
  // leaving IDLE; the header wait therefore spans RD_LAT+1 cycles. The data
  // pop is issued while in DRD itself, so the data wait spans RD_LAT cycles.
  localparam logic [1:0] HW_LAST = 2'(RD_LAT);
  localparam logic [1:0] DW_LAST = 2'(RD_LAT - 1);

  state_t         r_state;
  state_t         w_next;
  logic [6:0]     r_nsmp;
  logic [43:0]    r_hdr;
  logic [1:0]     r_wait;
  logic [1:0]     r_hidx;
  logic [3:0]     r_ch;
  logic [191:0]   r_shift;
  logic [9:0]     r_rd_cnt;
  logic [15:0]    r_wcnt;
  logic [15:0]    r_evt_cnt;
  logic           r_l1a_rd_en;
  logic [15:0]    r_rd_ena;
  logic [15:0]    r_dout;
  logic           r_valid;
  logic           r_sof;
  logic           r_eof;
  logic           r_busy;

  logic           w_accept;
  logic [9:0]     w_rd_tgt;
  logic           w_last_read;

  // Header word selector; H0 is built straight from the FIFO output so the
  // first word is ready in the same cycle the header is captured.
  function automatic logic [15:0] hdr_word(input logic [1:0] idx, input logic [43:0] hdr);
    logic [15:0] w;
    case (idx)
      2'd0:    w = {4'hA, hdr[23:12]};
      2'd1:    w = {4'hA, hdr[11:0]};
      2'd2:    w = {4'hA, hdr[35:24]};
      2'd3:    w = {4'hA, hdr[43:36], 4'h0};
      default: w = 16'h0000;
    endcase
    return w;
  endfunction

  assign w_accept    = r_valid & DOUT_READY;
  // Largest target is 6*128 = 768, which fits the 10-bit read counter.
  assign w_rd_tgt    = 10'(WPS) * ({3'b000, r_nsmp} + 10'd1);
  assign w_last_read = (r_rd_cnt == w_rd_tgt);

  // State register.
  always_ff @(posedge CLK40 or posedge srst) begin
    if (srst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (RDY) w_next = S_HWAIT;
        else     w_next = S_IDLE;
      end
      S_HWAIT: begin
        if (r_wait == HW_LAST) w_next = S_HDR;
        else                   w_next = S_HWAIT;
      end
      S_HDR: begin
        if (w_accept && (r_hidx == 2'd3)) w_next = S_DRD;
        else                              w_next = S_HDR;
      end
      S_DRD: begin
        w_next = S_DWAIT;
      end
      S_DWAIT: begin
        if (r_wait == DW_LAST) w_next = S_DOUT;
        else                   w_next = S_DWAIT;
      end
      S_DOUT: begin
        if (w_accept && (r_ch == 4'hF)) begin
          if (w_last_read) w_next = S_TRL;
          else             w_next = S_DRD;
        end else begin
          w_next = S_DOUT;
        end
      end
      S_TRL: begin
        if (w_accept) w_next = S_IDLE;
        else          w_next = S_TRL;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath, pop pulses and stream output registers; words only change on
  // acceptance so DOUT/SOF/EOF hold while the sink stalls.
  always_ff @(posedge CLK40 or posedge srst) begin
    if (srst) begin
      r_nsmp      <= 7'd0;
      r_hdr       <= 44'd0;
      r_wait      <= 2'd0;
      r_hidx      <= 2'd0;
      r_ch        <= 4'd0;
      r_shift     <= 192'd0;
      r_rd_cnt    <= 10'd0;
      r_wcnt      <= 16'd0;
      r_evt_cnt   <= 16'd0;
      r_l1a_rd_en <= 1'b0;
      r_rd_ena    <= 16'h0000;
      r_dout      <= 16'h0000;
      r_valid     <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_l1a_rd_en <= 1'b0;
      r_rd_ena    <= 16'h0000;
      r_busy      <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          r_wait <= 2'd0;
          if (RDY) begin
            r_l1a_rd_en <= 1'b1;
            r_nsmp      <= SAMP_MAX;
          end
        end
        S_HWAIT: begin
          if (r_wait == HW_LAST) begin
            r_hdr   <= L1A_SMP_OUT;
            r_dout  <= hdr_word(2'd0, L1A_SMP_OUT);
            r_valid <= 1'b1;
            r_sof   <= 1'b1;
            r_hidx  <= 2'd0;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_HDR: begin
          if (w_accept) begin
            r_sof <= 1'b0;
            if (r_hidx == 2'd3) begin
              r_valid  <= 1'b0;
              r_rd_ena <= 16'hFFFF;
              r_rd_cnt <= r_rd_cnt + 10'd1;
            end else begin
              r_hidx <= r_hidx + 2'd1;
              r_dout <= hdr_word(r_hidx + 2'd1, r_hdr);
            end
          end
        end
        S_DRD: begin
          r_wait <= 2'd0;
        end
        S_DWAIT: begin
          if (r_wait == DW_LAST) begin
            r_shift <= DOUT_16CH;
            r_dout  <= {4'h0, DOUT_16CH[11:0]};
            r_ch    <= 4'd0;
            r_valid <= 1'b1;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_DOUT: begin
          if (w_accept) begin
            r_wcnt <= r_wcnt + 16'd1;
            if (r_ch == 4'hF) begin
              if (w_last_read) begin
                r_dout <= r_wcnt + 16'd1;
                r_eof  <= 1'b1;
              end else begin
                r_valid  <= 1'b0;
                r_rd_ena <= 16'hFFFF;
                r_rd_cnt <= r_rd_cnt + 10'd1;
              end
            end else begin
              r_ch    <= r_ch + 4'd1;
              r_shift <= r_shift >> 12;
              r_dout  <= {r_ch + 4'd1, r_shift[23:12]};
            end
          end
        end
        S_TRL: begin
          if (w_accept) begin
            r_valid   <= 1'b0;
            r_eof     <= 1'b0;
            r_evt_cnt <= r_evt_cnt + 16'd1;
            r_rd_cnt  <= 10'd0;
            r_wcnt    <= 16'd0;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_sof   <= 1'b0;
          r_eof   <= 1'b0;
        end
      endcase
    end
  end

  assign L1A_RD_EN  = r_l1a_rd_en;
  assign RD_ENA     = r_rd_ena;
  assign DOUT       = r_dout;
  assign DOUT_VALID = r_valid;
  assign DOUT_SOF   = r_sof;
  assign DOUT_EOF   = r_eof;
  assign BUSY       = r_busy;
  assign EVT_CNT    = r_evt_cnt;

endmodule

// File: tb/tb_daq_fifo_readout.sv
// Testbench for daq_fifo_readout: FIFO responders and a stream recorder run
// on the falling edge; directed steps with random headers, data and sink
// stalls are compared against a stream model built from the event rules.

module tb_daq_fifo_readout;

  localparam int RD_LAT = 1;
  localparam int WPS    = 6;

  logic         CLK40 = 1'b1;
  logic         srst;
  logic         RDY;
  logic [43:0]  L1A_SMP_OUT;
  logic [191:0] DOUT_16CH;
  logic [6:0]   SAMP_MAX;
  logic         L1A_RD_EN;
  logic [15:0]  RD_ENA;
  logic [15:0]  DOUT;
  logic         DOUT_VALID;
  logic         DOUT_READY;
  logic         DOUT_SOF;
  logic         DOUT_EOF;
  logic         BUSY;
  logic [15:0]  EVT_CNT;

  int vectors;
  int miscompares;

  // Set by the stimulus block.
  logic [43:0]  hdr_tab [0:15];
  int           n_hdr;
  int           data_mode;
  int           ready_pct;
  logic [31:0]  seed;
  logic [17:0]  want_q [$];

  // Maintained by the responder/recorder.
  int           hdr_rd, hleft, cleft, rd_glob, cyc;
  int           rd_pulses, l1a_pulses, sof_cnt, eof_cnt, trl_cyc;
  int           ovr_err, outst_err, bits_err, stall_err, hold_err;
  logic         trl_seen, h0_seen, prev_valid, prev_ready;
  logic [17:0]  prev_word;
  logic [43:0]  hpend;
  logic [191:0] cpend;
  logic [17:0]  act [$];
  int           gaps [$];

  daq_fifo_readout #(.WPS(WPS), .RD_LAT(RD_LAT)) dut (
    .CLK40(CLK40), .srst(srst), .RDY(RDY), .L1A_SMP_OUT(L1A_SMP_OUT),
    .DOUT_16CH(DOUT_16CH), .SAMP_MAX(SAMP_MAX), .L1A_RD_EN(L1A_RD_EN),
    .RD_ENA(RD_ENA), .DOUT(DOUT), .DOUT_VALID(DOUT_VALID),
    .DOUT_READY(DOUT_READY), .DOUT_SOF(DOUT_SOF), .DOUT_EOF(DOUT_EOF),
    .BUSY(BUSY), .EVT_CNT(EVT_CNT)
  );

  always #5 CLK40 = ~CLK40;

  function automatic logic [11:0] chan_word(input int mode, input int g, input int ch);
    logic [31:0] h;
    if (mode == 0) return 12'h100 + 12'(ch);
    h = (32'(g) * 32'd2654435761) ^ (32'(ch) * 32'd40503) ^ seed;
    return h[19:8];
  endfunction

  // FIFO responders with RD_LAT latency, protocol watch and stream recorder.
  always @(negedge CLK40) begin
    cyc++;
    if (L1A_RD_EN) begin
      l1a_pulses++;
      if (hdr_rd >= n_hdr) ovr_err++;
      else begin hpend = hdr_tab[hdr_rd]; hdr_rd++; end
      L1A_SMP_OUT = {44{1'b1}};
      hleft = RD_LAT;
    end else if (hleft > 0) begin
      hleft--;
      if (hleft == 0) L1A_SMP_OUT = hpend;
    end
    RDY = (hdr_rd < n_hdr);
    if (RD_ENA != 16'h0000) begin
      rd_pulses++;
      if (RD_ENA != 16'hFFFF) bits_err++;
      if (cleft > 0) outst_err++;
      if (DOUT_VALID) stall_err++;
      for (int n = 0; n < 16; n++) cpend[12*n +: 12] = chan_word(data_mode, rd_glob, n);
      rd_glob++;
      DOUT_16CH = {192{1'b1}};
      cleft = RD_LAT;
    end else if (cleft > 0) begin
      cleft--;
      if (cleft == 0) DOUT_16CH = cpend;
    end
    if (!srst && prev_valid && !prev_ready &&
        (!DOUT_VALID || ({DOUT_SOF, DOUT_EOF, DOUT} != prev_word))) hold_err++;
    if (DOUT_VALID && DOUT_SOF && !h0_seen) begin
      h0_seen = 1'b1;
      if (trl_seen) gaps.push_back(cyc - trl_cyc - 1);
    end
    DOUT_READY = ($urandom_range(99, 0) < 32'(ready_pct));
    if (DOUT_VALID && DOUT_READY) begin
      act.push_back({DOUT_SOF, DOUT_EOF, DOUT});
      if (DOUT_SOF) begin sof_cnt++; h0_seen = 1'b0; end
      if (DOUT_EOF) begin eof_cnt++; trl_cyc = cyc; trl_seen = 1'b1; end
    end
    prev_valid = DOUT_VALID;
    prev_ready = DOUT_READY;
    prev_word  = {DOUT_SOF, DOUT_EOF, DOUT};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Reference stream of one event, from the header fields and read plan.
  task automatic add_event(input logic [43:0] h, input int smp, input int gbase, input int mode);
    logic [23:0] l1acnt;
    logic [11:0] l1amcnt;
    logic [3:0]  ovc;
    int          nrd;
    l1acnt  = h[23:0];
    l1amcnt = h[35:24];
    ovc     = h[39:36];
    nrd     = WPS * (smp + 1);
    want_q.push_back({2'b10, 4'hA, l1acnt[23:12]});
    want_q.push_back({2'b00, 4'hA, l1acnt[11:0]});
    want_q.push_back({2'b00, 4'hA, l1amcnt});
    want_q.push_back({2'b00, 4'hA, h[43], h[42], h[41], h[40], ovc, 4'h0});
    for (int r = 0; r < nrd; r++)
      for (int c = 0; c < 16; c++)
        want_q.push_back({2'b00, 4'(c), chan_word(mode, gbase + r, c)});
    want_q.push_back({2'b01, 16'(16 * nrd)});
  endtask

  task automatic cmp_stream(input int abase);
    chk("stream_len", 32'(act.size() - abase), 32'(want_q.size()));
    for (int i = 0; i < want_q.size() && (abase + i) < act.size(); i++)
      chk($sformatf("word%0d", i), 32'(act[abase + i]), 32'(want_q[i]));
  endtask

  task automatic wait_evt(input int nev, input int budget);
    logic [15:0] tgt;
    tgt = EVT_CNT + 16'(nev);
    for (int i = 0; i < budget && EVT_CNT != tgt; i++) @(negedge CLK40);
    chk("evt_cnt", 32'(EVT_CNT), 32'(tgt));
    repeat (4) @(negedge CLK40);
  endtask

  initial begin
    int abase, gbase, rb, lb, sb, eb, gb, ob;
    logic [43:0] h;
    srst = 1'b1; SAMP_MAX = 7'd0; n_hdr = 0; data_mode = 0; ready_pct = 100;
    seed = $urandom;
    repeat (3) @(negedge CLK40);

    // Reset state.
    chk("rst_out_a", {15'd0, L1A_RD_EN, RD_ENA}, 32'd0);
    chk("rst_out_b", {DOUT, DOUT_VALID, DOUT_SOF, DOUT_EOF, BUSY, 12'd0}, 32'd0);
    chk("rst_evt", 32'(EVT_CNT), 32'd0);
    srst = 1'b0;
    repeat (6) @(negedge CLK40);
    chk("idle_no_pop", 32'(l1a_pulses + rd_pulses), 32'd0);
    chk("idle_busy", 32'(BUSY), 32'd0);

    // Single event, fixed channel pattern, sink always ready.
    h = {8'($urandom), 12'h0AB, 24'h123456};
    want_q.delete(); abase = act.size(); rb = rd_pulses; lb = l1a_pulses;
    add_event(h, 0, rd_glob, 0);
    hdr_tab[n_hdr] = h; n_hdr++;
    wait_evt(1, 1000);
    cmp_stream(abase);
    chk("a_h0", 32'(act[abase]), {14'd0, 2'b10, 16'hA123});
    chk("a_trailer", 32'(act[act.size() - 1]), {14'd0, 2'b01, 16'h0060});
    chk("a_reads", 32'(rd_pulses - rb), 32'd6);
    chk("a_pops", 32'(l1a_pulses - lb), 32'd1);

    // Backpressure, random data, SAMP_MAX changed mid-event.
    ready_pct = 30; data_mode = 1; SAMP_MAX = 7'd7;
    h = {12'($urandom), 32'($urandom)};
    want_q.delete(); abase = act.size(); rb = rd_pulses; sb = stall_err;
    add_event(h, 7, rd_glob, 1);
    hdr_tab[n_hdr] = h; n_hdr++;
    repeat (40) @(negedge CLK40);
    SAMP_MAX = 7'd2;
    wait_evt(1, 20000);
    cmp_stream(abase);
    chk("b_reads", 32'(rd_pulses - rb), 32'd48);
    chk("b_rd_in_dout", 32'(stall_err - sb), 32'd0);
    chk("b_trailer", 32'(act[act.size() - 1]), {14'd0, 2'b01, 16'h0300});

    // Three events back to back.
    ready_pct = 100; SAMP_MAX = 7'd1;
    want_q.delete(); abase = act.size(); lb = l1a_pulses; sb = sof_cnt; eb = eof_cnt; gb = gaps.size();
    gbase = rd_glob;
    for (int e = 0; e < 3; e++) begin
      h = {12'($urandom), 32'($urandom)};
      add_event(h, 1, gbase + 12 * e, 1);
      hdr_tab[n_hdr + e] = h;
    end
    n_hdr = n_hdr + 3;
    wait_evt(3, 3000);
    cmp_stream(abase);
    chk("c_pops", 32'(l1a_pulses - lb), 32'd3);
    chk("c_sof", 32'(sof_cnt - sb), 32'd3);
    chk("c_eof", 32'(eof_cnt - eb), 32'd3);
    chk("c_gaps", 32'(gaps.size() - gb), 32'd3);
    if (gaps.size() >= gb + 3) begin
      chk("c_gap2", 32'(gaps[gb + 1]), 32'(2 + RD_LAT));
      chk("c_gap3", 32'(gaps[gb + 2]), 32'(2 + RD_LAT));
    end

    // Largest event.
    SAMP_MAX = 7'd127;
    h = {12'($urandom), 32'($urandom)};
    want_q.delete(); abase = act.size(); rb = rd_pulses;
    add_event(h, 127, rd_glob, 1);
    hdr_tab[n_hdr] = h; n_hdr++;
    wait_evt(1, 30000);
    cmp_stream(abase);
    chk("d_reads", 32'(rd_pulses - rb), 32'd768);
    chk("d_trailer", 32'(act[act.size() - 1]), {14'd0, 2'b01, 16'h3000});
    chk("fifo_protocol", 32'(ovr_err + outst_err + bits_err + hold_err), 32'd0);

    // Reset in the middle of the data words.
    SAMP_MAX = 7'd1;
    hdr_tab[n_hdr] = {12'($urandom), 32'($urandom)}; n_hdr++;
    abase = act.size();
    for (int i = 0; i < 300 && (act.size() - abase) < 10; i++) @(negedge CLK40);
    chk("e_in_data", 32'((act.size() - abase) >= 10), 32'd1);
    srst = 1'b1;
    @(posedge CLK40); #1;
    chk("e_rst_a", {15'd0, L1A_RD_EN, RD_ENA}, 32'd0);
    chk("e_rst_b", {DOUT, DOUT_VALID, DOUT_SOF, DOUT_EOF, BUSY, 12'd0}, 32'd0);
    chk("e_rst_evt", 32'(EVT_CNT), 32'd0);
    @(negedge CLK40);
    srst = 1'b0;
    repeat (3) @(negedge CLK40);
    lb = l1a_pulses; rb = rd_pulses;
    repeat (20) @(negedge CLK40);
    chk("e_no_pops", 32'(l1a_pulses - lb + rd_pulses - rb), 32'd0);
    chk("e_busy", 32'(BUSY), 32'd0);

    // Recovery after reset.
    SAMP_MAX = 7'd0;
    h = {12'($urandom), 32'($urandom)};
    want_q.delete(); abase = act.size(); ob = outst_err;
    add_event(h, 0, rd_glob, 1);
    hdr_tab[n_hdr] = h; n_hdr++;
    wait_evt(1, 1000);
    cmp_stream(abase);
    chk("e_evt_cnt", 32'(EVT_CNT), 32'd1);
    chk("e_protocol", 32'(outst_err - ob + ovr_err + bits_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
